// File: rtl/imm_encode_loader_pkg.sv
// +--------------------------------------------------------------------------+
// | imm_encode_loader_pkg: opcodes, in_fmt codes and loader FSM encoding       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package imm_encode_loader_pkg;

  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_I_LD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_I_LD = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_SB   = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imm_encode_loader_imm_pack.sv
// +--------------------------------------------------------------------------+
// | imm_pack: range-checks an immediate and packs it into an RV32I word.      |
// | Optional J format enabled by macro IMMENC_JAL_EN.   Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_pack
  import imm_encode_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        ok,
  output logic [31:0] word
);

  always_comb begin
    ok   = 1'b0;
    word = '0;
    case (fmt)
      FMT_I, FMT_I_LD: begin
        ok   = (imm[31:11] == {21{imm[11]}});
        word = {imm[11:0], rs1, funct3, rd, (fmt == FMT_I) ? OP_I : OP_I_LD};
      end
      FMT_S: begin
        ok   = (imm[31:11] == {21{imm[11]}});
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      end
      FMT_SB: begin
        // Branch offsets are a sign-extended 13-bit even value
        ok   = (imm[31:12] == {20{imm[12]}}) && !imm[0];
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_SB};
      end
`ifdef IMMENC_JAL_EN
      FMT_J: begin
        ok   = (imm[31:20] == {12{imm[20]}}) && !imm[0];
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
      end
`endif
      default: begin
        ok   = 1'b0;
        word = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_encode_loader.sv
// +--------------------------------------------------------------------------+
// | imm_encode_loader: encodes field bundles and streams them into imem.      |
// | J format enabled by macro IMMENC_JAL_EN.   Rev 1.0                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_encode_loader
  import imm_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   remaining;
  logic [ADDR_W-1:0]  next_addr;
  logic               accept;
  logic               pack_ok;
  logic [31:0]        pack_word;

  imm_pack u_pack (
    .fmt    (in_fmt),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .ok     (pack_ok),
    .word   (pack_word)
  );

  assign accept = in_valid & in_ready;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = (count == '0) ? S_FIN : S_LOAD;
      S_LOAD: begin
        in_ready = (remaining != '0);
        if (accept && remaining == CNT_W'(1)) state_n = S_FIN;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      next_addr  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state == S_IDLE && start) begin
        remaining <= count;
        next_addr <= base_addr;
        err       <= 1'b0;
        err_cnt   <= '0;
      end
      if (accept) begin
        remaining <= remaining - CNT_W'(1);
        // Rejected bundles leave the write address untouched
        if (pack_ok) begin
          imem_we    <= 1'b1;
          imem_addr  <= next_addr;
          imem_wdata <= pack_word;
          next_addr  <= next_addr + ADDR_W'(4);
        end else begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_encode_loader.sv
// +--------------------------------------------------------------------------+
// | tb_imm_encode_loader: directed scoreboard bench for imm_encode_loader.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imm_encode_loader;
  import imm_encode_loader_pkg::*;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              in_ready;
  logic [2:0]        in_fmt, in_funct3;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm;
  logic              imem_we, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [CNT_W-1:0]  err_cnt;

  always #5 clk = ~clk;

  imm_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               sb[$];
  int                vecs = 0;
  int                errs = 0;
  logic [ADDR_W-1:0] exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; any write seen is matched against the scoreboard head
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (imem_we !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        w = sb.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(w.addr));
        check("wr_data", imem_wdata, w.data);
      end
    end
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    exp_addr  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                      input bit ok, input logic [31:0] word);
    int n;
    in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    if (ok) begin
      sb.push_back('{addr: exp_addr, data: word});
      exp_addr = exp_addr + ADDR_W'(4);
    end
    tick();
    check("write_latency", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0; count = '0;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
    exp_addr = '0;
    repeat (3) tick();
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_errcnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Single I instruction
    start_burst(12'h100, 10'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 32'h00500093);
    in_valid = 1'b0;
    check("t1_done", {31'd0, done}, 32'd1);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // Back-to-back S / SB / I_LD
    start_burst(12'h100, 10'd3);
    send(FMT_S,    5'd0, 5'd1, 5'd2, 3'd2, 32'd8,  1'b1, 32'h0020A423);
    send(FMT_SB,   5'd0, 5'd1, 5'd2, 3'd0, -32'sd4, 1'b1, 32'hFE208EE3);
    send(FMT_I_LD, 5'd3, 5'd1, 5'd0, 3'd2, 32'd0,  1'b1, 32'h0000A183);
    in_valid = 1'b0;
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_err", {31'd0, err}, 32'd0);
    tick();

    // Two rejects then one good
    start_burst(12'h100, 10'd3);
    send(FMT_I,  5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0, 32'd0);
    send(FMT_SB, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3,    1'b0, 32'd0);
    check("t3_not_done", {31'd0, done}, 32'd0);
    send(FMT_I,  5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
    in_valid = 1'b0;
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_errcnt", 32'(err_cnt), 32'd2);
    tick();

    // Range boundaries and an illegal format
    start_burst(12'h3F8, 10'd5);
    send(FMT_I,  5'd1, 5'd0, 5'd0, 3'd0, -32'sd2048, 1'b1, 32'h80000093);
    send(FMT_SB, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094,   1'b1, 32'h7E000FE3);
    send(FMT_S,  5'd0, 5'd0, 5'd0, 3'd0, -32'sd2049, 1'b0, 32'd0);
    send(3'd7,   5'd1, 5'd0, 5'd0, 3'd0, 32'd0,      1'b0, 32'd0);
    send(FMT_SB, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4096, 1'b1, 32'h80000063);
    in_valid = 1'b0;
    check("t4_errcnt", 32'(err_cnt), 32'd2);
    tick();

    // start during LOAD is ignored
    start_burst(12'h200, 10'd2);
    start = 1'b1; base_addr = 12'h300; count = 10'd5;
    send(FMT_I, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1, 1'b1, 32'h00100113);
    start = 1'b0;
    send(FMT_I, 5'd3, 5'd0, 5'd0, 3'd0, 32'd2, 1'b1, 32'h00200193);
    in_valid = 1'b0;
    check("t5_done", {31'd0, done}, 32'd1);
    tick();
    check("t5_idle", {31'd0, busy}, 32'd0);

    // count == 0, valid held throughout
    in_valid = 1'b1;
    start_burst(12'h040, 10'd0);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("t6_done_pulse", {31'd0, done}, 32'd0);
    repeat (3) begin
      tick();
      check("t6_ready_idle", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    // J format
    start_burst(12'h080, 10'd1);
`ifdef IMMENC_JAL_EN
    send(FMT_J, 5'd1, 5'd0, 5'd0, 3'd0, 32'd16, 1'b1, 32'h010000EF);
    in_valid = 1'b0;
    check("t7_err", {31'd0, err}, 32'd0);
`else
    send(FMT_J, 5'd1, 5'd0, 5'd0, 3'd0, 32'd16, 1'b0, 32'd0);
    in_valid = 1'b0;
    check("t7_err", {31'd0, err}, 32'd1);
`endif
    tick();

    // Reset mid-burst
    start_burst(12'h020, 10'd4);
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd7, 1'b1, 32'h00700093);
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, 1'b1, 32'h00800093);
    rst = 1'b1;
    tick();
    check("t8_busy", {31'd0, busy}, 32'd0);
    check("t8_we", {31'd0, imem_we}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    start_burst(12'h000, 10'd1);
    send(FMT_I, 5'd4, 5'd0, 5'd0, 3'd0, 32'd9, 1'b1, 32'h00900213);
    in_valid = 1'b0;
    check("t8_done", {31'd0, done}, 32'd1);
    tick();
    repeat (2) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
